// File: rtl/la_vdemux8_pipe.sv
// One-hot, registered 8-lane demultiplexer with valid/ready flow control.
// A single holding entry steers each accepted word to one lane; illegal selects are counted and dropped.
module la_vdemux8_pipe #(
  parameter int N    = 1,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_sel,
  input  logic [N-1:0] in,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [N-1:0] out7,
  output logic [N-1:0] out6,
  output logic [N-1:0] out5,
  output logic [N-1:0] out4,
  output logic [N-1:0] out3,
  output logic [N-1:0] out2,
  output logic [N-1:0] out1,
  output logic [N-1:0] out0,
  output logic         err,
  output logic [7:0]   err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [7:0]     sel_q, sel_d;
  logic [N-1:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           drain, accept, legal;

  function automatic logic is_onehot(input logic [7:0] s);
    return (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready depends only on held state and out_ready, never on the source side.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    drain   = (state_q == FULL) && ((sel_q & out_ready) != 8'd0);
    in_ready = (state_q == EMPTY) || drain;
    legal   = is_onehot(in_sel);
    accept  = in_valid && in_ready;

    if (accept && legal) begin
      state_d = FULL;
      sel_d   = in_sel;
      data_d  = in;
    end else begin
      if (drain) state_d = EMPTY;
      if (accept) begin
        err_d = 1'b1;
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  assign out_valid = {8{state_q == FULL}} & sel_q;
  assign out0      = {N{out_valid[0]}} & data_q;
  assign out1      = {N{out_valid[1]}} & data_q;
  assign out2      = {N{out_valid[2]}} & data_q;
  assign out3      = {N{out_valid[3]}} & data_q;
  assign out4      = {N{out_valid[4]}} & data_q;
  assign out5      = {N{out_valid[5]}} & data_q;
  assign out6      = {N{out_valid[6]}} & data_q;
  assign out7      = {N{out_valid[7]}} & data_q;
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: doc/la_vdemux8_pipe.md
Name: la_vdemux8_pipe

Overview:
- 8-output, one-hot, registered vectorized demultiplexer with valid/ready flow control.
- It is the fan-out counterpart of the one-hot vectorized mux: it steers one N-bit source stream to exactly one of eight destination lanes.
- It sits between a shared producer (e.g. a bus or port arbiter) and eight consumers.
- It provides one pipeline register stage, full throughput, and detection and drop of illegal (non-one-hot) selects.

Parameters:
- N, 1, data width of input and of each output lane.
- PROP, "DEFAULT", cell property string, passed through for implementation selection; no functional effect.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- in_valid  input  1  source word valid.
- in_ready  output  1  block can accept the source word this cycle.
- in_sel  input  8  one-hot destination select, qualified by in_valid.
- in  input  N  source data.
- out_valid  output  8  per-lane valid; bit k qualifies outk.
- out_ready  input  8  per-lane consumer ready.
- out7 .. out0  output  N each  lane data; zero when that lane is not valid.
- err  output  1  one-cycle pulse: an accepted transfer had an illegal in_sel.
- err_count  output  8  saturating count of illegal-select transfers.

Behaviour:
- Clock and reset: one clock domain (clk); nreset is asynchronous assert, active-low.
- Reset values: valid_q=0, sel_q=0, data_q=0, err=0, err_count=0. Hence in_ready=1, out_valid=0, all outk=0.
- State: single holding entry {valid_q, sel_q[7:0], data_q[N-1:0]}; two states, EMPTY (valid_q=0) and FULL (valid_q=1).
- Drain condition: drain = valid_q & |(sel_q & out_ready).
- in_ready = ~valid_q | drain. This is combinational from out_ready; there is no combinational path from in_valid, in_sel or in to any output.
- Accept condition: accept = in_valid & in_ready.
- legal = in_sel has exactly one bit set.
- accept & legal: load data_q=in, sel_q=in_sel, valid_q=1. State becomes or stays FULL.
- accept & ~legal (in_sel zero or multi-hot):
  - The word is consumed (handshake completes) and discarded.
  - err=1 on the next cycle.
  - err_count increments, saturating at 255.
  - valid_q becomes 0 if drain this cycle, else holds.
- No accept: valid_q clears on drain, else holds. err=0 next cycle.
- Outputs:
  - out_valid[k] = valid_q & sel_q[k].
  - outk = {N{out_valid[k]}} & data_q.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle when the destination lane is ready (simultaneous drain and load in the same cycle).
- Backpressure: while FULL and the selected lane's out_ready=0:
  - in_ready=0.
  - out_valid, sel_q and data_q are held stable until drained.
- Ready on non-selected lanes has no effect.
- Back-to-back words to different lanes: lane switches in the cycle after drain; no bubble.
- Reset mid-operation: any held word is lost, err_count is cleared, and outputs return to reset values immediately (asynchronous).
- Only one lane is ever valid; out_valid is always zero or one-hot.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0x00, all outk=0, err=0, err_count=0.
- Streaming, N=8: in_sel cycles 0x01,0x02..0x80 with in=0x10..0x17, all out_ready=1 → one word per cycle, each arrives on lane k one cycle later (out3=0x13 with out_valid=0x08), other lanes 0, no bubbles.
- Backpressure: send in=0xA5, in_sel=0x04, hold out_ready[2]=0 for 3 cycles with out_ready on all other lanes=1 → in_ready=0, out2=0xA5 stable 3 cycles; release → drains, next queued word accepted in the same cycle.
- Illegal select: in_sel=0x00 and then 0x11 (each with in_valid=1) → both consumed, no out_valid, err pulses each cycle after, err_count=2; 300 illegal words → err_count saturates at 255.
- Illegal select while FULL and draining: held word on lane 5 drains as an illegal word arrives → valid_q=0 after, err=1, no lane valid.
- Async reset while FULL and stalled: assert nreset low mid-cycle → out_valid=0x00 and err_count=0 immediately; after release, in_ready=1.
